// File: rtl/udma_pkg.sv
// udma_pkg: shared uDMA configuration-port types and constants.
package udma_pkg;
  localparam int CFG_ADDR_W = 5;
  localparam logic [31:0] CFG_ERR_DATA = 32'hDEAD_BEEF;
  typedef struct packed {
    logic [31:0]           data;
    logic [CFG_ADDR_W-1:0] addr;
    logic                  valid;
    logic                  rwn;
  } cfg_req_t;
  typedef struct packed {
    logic        ready;
    logic [31:0] data;
  } cfg_rsp_t;
  typedef enum logic {IDLE, GRANT} arb_state_e;
endpackage

// File: rtl/udma_cfg_rr_pick.sv
// udma_cfg_rr_pick: combinational rotate-priority pick of the first request at or after ptr_i.
module udma_cfg_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] j;
  // Scanning from the farthest slot back to ptr_i lets the nearest request win last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (req_i[j]) begin
        idx_o = j;
        gnt_o = '0;
        gnt_o[j] = 1'b1;
      end
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/udma_cfg_arbiter.sv
// udma_cfg_arbiter: round-robin sharing of one uDMA cfg port between NUM_MASTERS requesters,
// with read-data routing back to the owner and timeout completion of stalled accesses.
module udma_cfg_arbiter
  import udma_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic [NUM_MASTERS-1:0][31:0]           m_cfg_data_i,
  input  logic [NUM_MASTERS-1:0][CFG_ADDR_W-1:0] m_cfg_addr_i,
  input  logic [NUM_MASTERS-1:0]                 m_cfg_valid_i,
  input  logic [NUM_MASTERS-1:0]                 m_cfg_rwn_i,
  output logic [NUM_MASTERS-1:0]                 m_cfg_ready_o,
  output logic [NUM_MASTERS-1:0][31:0]           m_cfg_data_o,
  output logic [31:0]                            s_cfg_data_o,
  output logic [CFG_ADDR_W-1:0]                  s_cfg_addr_o,
  output logic                                   s_cfg_valid_o,
  output logic                                   s_cfg_rwn_o,
  input  logic                                   s_cfg_ready_i,
  input  logic [31:0]                            s_cfg_data_i,
  output logic [NUM_MASTERS-1:0]                 grant_o,
  output logic                                   err_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  cfg_req_t req [NUM_MASTERS];
  cfg_rsp_t rsp [NUM_MASTERS];
  cfg_req_t own;
  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, pick_gnt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pick_any, in_grant, hs, to;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_map
    assign req[g] = '{data: m_cfg_data_i[g], addr: m_cfg_addr_i[g], valid: m_cfg_valid_i[g], rwn: m_cfg_rwn_i[g]};
    assign m_cfg_ready_o[g] = rsp[g].ready;
    assign m_cfg_data_o[g] = rsp[g].data;
  end

  udma_cfg_rr_pick #(.NUM_REQ(NUM_MASTERS)) u_pick (
    .req_i (m_cfg_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign own = req[owner_q];
  assign in_grant = state_q == GRANT;
  assign hs = in_grant & own.valid & s_cfg_ready_i;
  // A handshake in the timeout cycle takes priority, so the timeout only fires without slave ready.
  assign to = in_grant & own.valid & ~s_cfg_ready_i & (TIMEOUT_CYCLES != 0) & (cnt_q == CW'(TIMEOUT_CYCLES));
  assign s_cfg_valid_o = in_grant & own.valid & ~to;
  assign s_cfg_data_o = in_grant ? own.data : '0;
  assign s_cfg_addr_o = in_grant ? own.addr : '0;
  assign s_cfg_rwn_o = in_grant ? own.rwn : 1'b0;
  assign grant_o = in_grant ? grant_q : '0;
  assign err_o = to;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rsp[i].ready = (hs | to) & (owner_q == IW'(i));
      rsp[i].data = rsp[i].ready ? (to ? CFG_ERR_DATA : s_cfg_data_i) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (!in_grant) begin
      if (pick_any) begin
        state_d = GRANT;
        owner_d = pick_idx;
        grant_d = pick_gnt;
        cnt_d = '0;
      end
    end else if (hs | to) begin
      state_d = IDLE;
      ptr_d = owner_q == IW'(NUM_MASTERS - 1) ? '0 : owner_q + 1'b1;
    end else if (!own.valid) begin
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_udma_cfg_arbiter.sv
// tb_udma_cfg_arbiter: directed tests with a per-cycle behavioural model and hand-computed spot checks.
module tb_udma_cfg_arbiter;
  localparam int N = 4;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0][31:0] m_data, m_rdata;
  logic [N-1:0][4:0] m_addr;
  logic [N-1:0] m_valid, m_rwn, m_ready, grant;
  logic [31:0] s_wdata, s_rdata;
  logic [4:0] s_addr;
  logic s_valid, s_rwn, s_ready, err;
  int checks = 0;
  int fails = 0;
  logic [3:0] rr_exp [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

  always #5 clk = ~clk;

  udma_cfg_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .m_cfg_data_i  (m_data),
    .m_cfg_addr_i  (m_addr),
    .m_cfg_valid_i (m_valid),
    .m_cfg_rwn_i   (m_rwn),
    .m_cfg_ready_o (m_ready),
    .m_cfg_data_o  (m_rdata),
    .s_cfg_data_o  (s_wdata),
    .s_cfg_addr_o  (s_addr),
    .s_cfg_valid_o (s_valid),
    .s_cfg_rwn_o   (s_rwn),
    .s_cfg_ready_i (s_ready),
    .s_cfg_data_i  (s_rdata),
    .grant_o       (grant),
    .err_o         (err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port, where the rotation resumes, and how long the owner has waited.
  bit busy, v, hs, to, found;
  int own, ptr, waited;
  logic [N-1:0] e_ready, e_grant;
  logic [N-1:0][31:0] e_rdata;
  logic [31:0] e_sd;
  logic [4:0] e_sa;
  logic e_sv, e_rwn, e_err;

  always @(negedge clk) begin
    e_ready = '0; e_grant = '0; e_rdata = '0; e_sd = '0; e_sa = '0;
    e_sv = 1'b0; e_rwn = 1'b0; e_err = 1'b0; v = 0; hs = 0; to = 0;
    if (!rstn) begin
      busy = 0; own = 0; ptr = 0; waited = 0;
    end else if (busy) begin
      v = m_valid[own];
      hs = v && s_ready;
      to = v && !s_ready && waited == T;
      e_grant[own] = 1'b1;
      e_sv = v && !to;
      e_sd = m_data[own];
      e_sa = m_addr[own];
      e_rwn = m_rwn[own];
      e_err = to;
      if (hs || to) begin
        e_ready[own] = 1'b1;
        e_rdata[own] = to ? 32'hDEAD_BEEF : s_rdata;
      end
    end
    chk("m_grant", grant, e_grant);
    chk("m_ready", m_ready, e_ready);
    chk("m_rdata", m_rdata, e_rdata);
    chk("m_svalid", s_valid, e_sv);
    chk("m_sdata", s_wdata, e_sd);
    chk("m_saddr", s_addr, e_sa);
    chk("m_srwn", s_rwn, e_rwn);
    chk("m_err", err, e_err);
    if (rstn) begin
      if (!busy) begin
        found = 0;
        for (int k = 0; k < N; k++)
          if (!found && m_valid[(ptr + k) % N]) begin
            found = 1; busy = 1; own = (ptr + k) % N; waited = 0;
          end
      end else if (hs || to) begin
        busy = 0; ptr = (own + 1) % N;
      end else if (!v) begin
        busy = 0;
      end else begin
        waited++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    m_valid = '0; m_rwn = '0; m_addr = '0; m_data = '0; s_ready = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    clr();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  initial begin
    clr();
    step(2);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ready", m_ready, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_svalid", s_valid, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;
    // single read
    step();
    m_valid[0] = 1'b1; m_addr[0] = 5'h04; m_rwn[0] = 1'b1; m_data[0] = 32'hAAAA_0000;
    step(); #1;
    chk("rd_svalid_t1", s_valid, 1);
    chk("rd_saddr_t1", s_addr, 5'h04);
    chk("rd_grant_t1", grant, 4'h1);
    step();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    chk("rd_ready_t2", m_ready, 4'h1);
    chk("rd_data_t2", m_rdata[0], 32'h1234_5678);
    step();
    clr();
    #1;
    chk("rd_grant_t3", grant, 4'h0);
    // round robin, all masters requesting, slave always ready
    do_reset();
    m_valid = '1; s_ready = 1'b1; s_rdata = 32'h0000_0100;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("rr_grant", grant, rr_exp[c]);
      chk("rr_ready", m_ready, rr_exp[c]);
      step();
    end
    clr();
    // timeout on m1 write, m0 joins later
    do_reset();
    m_valid[1] = 1'b1; m_addr[1] = 5'h1F; m_data[1] = 32'hCAFE_0001;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 5) m_valid[0] = 1'b1;
      #1;
      if (c <= 8) begin
        chk("to_wait_ready", m_ready, 4'h0);
        chk("to_wait_svalid", s_valid, 1);
        chk("to_wait_err", err, 0);
      end else begin
        chk("to_ready", m_ready, 4'h2);
        chk("to_data", m_rdata[1], 32'hDEAD_BEEF);
        chk("to_err", err, 1);
        chk("to_svalid", s_valid, 0);
      end
    end
    step(); #1;
    chk("to_idle", grant, 4'h0);
    step();
    s_ready = 1'b1;
    #1;
    chk("to_next_m0", grant, 4'h1);
    chk("to_next_ready", m_ready, 4'h1);
    step();
    clr();
    // handshake in the timeout cycle
    do_reset();
    m_valid[2] = 1'b1; m_rwn[2] = 1'b1; m_addr[2] = 5'h0A;
    step(8);
    step();
    s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
    #1;
    chk("co_ready", m_ready, 4'h4);
    chk("co_data", m_rdata[2], 32'h5555_AAAA);
    chk("co_err", err, 0);
    chk("co_svalid", s_valid, 1);
    step();
    clr();
    // abort by owner
    do_reset();
    m_valid[0] = 1'b1; m_valid[1] = 1'b1;
    step(2);
    step();
    m_valid[0] = 1'b0;
    #1;
    chk("ab_ready", m_ready, 4'h0);
    chk("ab_grant", grant, 4'h1);
    chk("ab_svalid", s_valid, 0);
    step();
    m_valid[0] = 1'b1;
    #1;
    chk("ab_idle", grant, 4'h0);
    step();
    s_ready = 1'b1;
    #1;
    chk("ab_ptr_kept", grant, 4'h1);
    step();
    clr();
    // asynchronous reset during GRANT
    do_reset();
    m_valid[1] = 1'b1; m_addr[1] = 5'h03;
    step(); #1;
    chk("ar_grant", grant, 4'h2);
    #1;
    rstn = 1'b0; s_ready = 1'b1;
    #1;
    chk("ar_grant0", grant, 4'h0);
    chk("ar_svalid0", s_valid, 0);
    chk("ar_ready0", m_ready, 4'h0);
    chk("ar_saddr0", s_addr, 5'h00);
    step();
    rstn = 1'b1;
    #1;
    chk("ar_rel_idle", grant, 4'h0);
    step(); #1;
    chk("ar_regrant", grant, 4'h2);
    chk("ar_ready", m_ready, 4'h2);
    step();
    clr();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
